// File: rtl/voice_allocator.sv
// voice_allocator
//   Scans note gates one group of NOTES_PER_GROUP notes per clock and packs
//   up to NUM_VOICES gated notes into voice slots, lowest note index first.
//   A frame is NUM_GROUPS scan cycles followed by one commit cycle. The commit
//   publishes an atomic snapshot of the allocation and pulses frame_valid.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous active-low reset
//   phase_in          per-note phase accumulator value
//   gate_in           per-note key-down
//   addr_out          per-note wavetable address (0 for ungated/dropped notes)
//   voice_addr_out    wavetable address per voice slot (snapshot)
//   active_voices_idx note index per voice slot, all-ones when unused (snapshot)
//   active_voices     notes currently holding a voice (snapshot)
//   num_voices        number of voices in use (snapshot)
//   frame_valid       one-cycle pulse when a new snapshot is published
//
// Optional feature: define VOICE_ALLOC_DROP_COUNT_EN to add
//   dropped_count     gated notes without a free voice last frame (saturates at 255)
//   overflow          high when the published dropped_count is non-zero
module voice_allocator #(
  parameter  int unsigned NUM_NOTES       = 24,
  parameter  int unsigned NUM_VOICES      = 8,
  parameter  int unsigned NOTES_PER_GROUP = 8,
  parameter  int unsigned PHASE_WIDTH     = 32,
  parameter  int unsigned ADDR_WIDTH      = 8,
  localparam int unsigned NOTE_IDX_WIDTH  = $clog2(NUM_NOTES),
  localparam int unsigned VOICE_CNT_WIDTH = $clog2(NUM_VOICES + 1)
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic [NUM_NOTES-1:0][PHASE_WIDTH-1:0]      phase_in,
  input  logic [NUM_NOTES-1:0]                       gate_in,
  output logic [NUM_NOTES-1:0][ADDR_WIDTH-1:0]       addr_out,
  output logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0]      voice_addr_out,
  output logic [NUM_VOICES-1:0][NOTE_IDX_WIDTH-1:0]  active_voices_idx,
  output logic [NUM_NOTES-1:0]                       active_voices,
  output logic [VOICE_CNT_WIDTH-1:0]                 num_voices,
`ifdef VOICE_ALLOC_DROP_COUNT_EN
  output logic [7:0]                                 dropped_count,
  output logic [0:0]                                 overflow,
`endif
  output logic                                       frame_valid
);

  localparam int unsigned NUM_GROUPS = (NUM_NOTES + NOTES_PER_GROUP - 1) / NOTES_PER_GROUP;
  localparam int unsigned SCAN_WIDTH = $clog2(NUM_GROUPS + 1);
  localparam logic [SCAN_WIDTH-1:0]      COMMIT_CNT = SCAN_WIDTH'(NUM_GROUPS);
  localparam logic [VOICE_CNT_WIDTH-1:0] MAX_VOICES = VOICE_CNT_WIDTH'(NUM_VOICES);

  // Scan counter: 0..NUM_GROUPS-1 scan a group, NUM_GROUPS commits.
  logic [SCAN_WIDTH-1:0] scan_q, scan_d;

  // Working (in-progress frame) state.
  logic [VOICE_CNT_WIDTH-1:0]                wk_cnt_q,    wk_cnt_d;
  logic [NUM_NOTES-1:0]                      wk_active_q, wk_active_d;
  logic [NUM_VOICES-1:0][NOTE_IDX_WIDTH-1:0] wk_idx_q,    wk_idx_d;
  logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0]     wk_vaddr_q,  wk_vaddr_d;

  // Per-note address and published snapshot.
  logic [NUM_NOTES-1:0][ADDR_WIDTH-1:0]      addr_q,        addr_d;
  logic [VOICE_CNT_WIDTH-1:0]                snap_cnt_q,    snap_cnt_d;
  logic [NUM_NOTES-1:0]                      snap_active_q, snap_active_d;
  logic [NUM_VOICES-1:0][NOTE_IDX_WIDTH-1:0] snap_idx_q,    snap_idx_d;
  logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0]     snap_vaddr_q,  snap_vaddr_d;
  logic                                      frame_valid_q, frame_valid_d;

`ifdef VOICE_ALLOC_DROP_COUNT_EN
  logic [7:0] wk_drop_q,   wk_drop_d;
  logic [7:0] snap_drop_q, snap_drop_d;
`endif

  // Only the top ADDR_WIDTH bits of each phase address the wavetable.
  logic unused_phase_bits;
  assign unused_phase_bits = ^phase_in;

  always_comb begin
    scan_d        = (scan_q == COMMIT_CNT) ? '0 : scan_q + 1'b1;
    wk_cnt_d      = wk_cnt_q;
    wk_active_d   = wk_active_q;
    wk_idx_d      = wk_idx_q;
    wk_vaddr_d    = wk_vaddr_q;
    addr_d        = addr_q;
    snap_cnt_d    = snap_cnt_q;
    snap_active_d = snap_active_q;
    snap_idx_d    = snap_idx_q;
    snap_vaddr_d  = snap_vaddr_q;
    frame_valid_d = 1'b0;
`ifdef VOICE_ALLOC_DROP_COUNT_EN
    wk_drop_d     = wk_drop_q;
    snap_drop_d   = snap_drop_q;
`endif

    if (scan_q == COMMIT_CNT) begin
      snap_cnt_d    = wk_cnt_q;
      snap_active_d = wk_active_q;
      snap_idx_d    = wk_idx_q;
      snap_vaddr_d  = wk_vaddr_q;
      frame_valid_d = 1'b1;
      wk_cnt_d      = '0;
      wk_active_d   = '0;
      wk_idx_d      = '1;
      wk_vaddr_d    = '0;
`ifdef VOICE_ALLOC_DROP_COUNT_EN
      snap_drop_d   = wk_drop_q;
      wk_drop_d     = '0;
`endif
    end else begin
      // wk_cnt_d is the running slot pointer; walking notes in ascending
      // order within the group gives lowest-index-first allocation.
      for (int unsigned n = 0; n < NUM_NOTES; n++) begin
        if (SCAN_WIDTH'(n / NOTES_PER_GROUP) == scan_q) begin
          if (gate_in[n] && (wk_cnt_d < MAX_VOICES)) begin
            wk_active_d[n] = 1'b1;
            for (int unsigned s = 0; s < NUM_VOICES; s++) begin
              if (VOICE_CNT_WIDTH'(s) == wk_cnt_d) begin
                wk_idx_d[s]   = NOTE_IDX_WIDTH'(n);
                wk_vaddr_d[s] = phase_in[n][PHASE_WIDTH-1 -: ADDR_WIDTH];
              end
            end
            wk_cnt_d  = wk_cnt_d + 1'b1;
            addr_d[n] = phase_in[n][PHASE_WIDTH-1 -: ADDR_WIDTH];
          end else begin
            addr_d[n] = '0;
`ifdef VOICE_ALLOC_DROP_COUNT_EN
            if (gate_in[n] && (wk_drop_d != 8'hFF)) begin
              wk_drop_d = wk_drop_d + 8'd1;
            end
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      scan_q        <= '0;
      wk_cnt_q      <= '0;
      wk_active_q   <= '0;
      wk_idx_q      <= '1;
      wk_vaddr_q    <= '0;
      addr_q        <= '0;
      snap_cnt_q    <= '0;
      snap_active_q <= '0;
      snap_idx_q    <= '1;
      snap_vaddr_q  <= '0;
      frame_valid_q <= 1'b0;
`ifdef VOICE_ALLOC_DROP_COUNT_EN
      wk_drop_q     <= '0;
      snap_drop_q   <= '0;
`endif
    end else begin
      scan_q        <= scan_d;
      wk_cnt_q      <= wk_cnt_d;
      wk_active_q   <= wk_active_d;
      wk_idx_q      <= wk_idx_d;
      wk_vaddr_q    <= wk_vaddr_d;
      addr_q        <= addr_d;
      snap_cnt_q    <= snap_cnt_d;
      snap_active_q <= snap_active_d;
      snap_idx_q    <= snap_idx_d;
      snap_vaddr_q  <= snap_vaddr_d;
      frame_valid_q <= frame_valid_d;
`ifdef VOICE_ALLOC_DROP_COUNT_EN
      wk_drop_q     <= wk_drop_d;
      snap_drop_q   <= snap_drop_d;
`endif
    end
  end

  assign addr_out          = addr_q;
  assign voice_addr_out    = snap_vaddr_q;
  assign active_voices_idx = snap_idx_q;
  assign active_voices     = snap_active_q;
  assign num_voices        = snap_cnt_q;
  assign frame_valid       = frame_valid_q;
`ifdef VOICE_ALLOC_DROP_COUNT_EN
  assign dropped_count     = snap_drop_q;
  assign overflow          = (snap_drop_q != 8'd0);
`endif

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
  localparam int NN = 24, NV = 8, PW = 32, AW = 8, IW = 5, CW = 4;
  localparam int SN = 10, SV = 3, SIW = 4, SCW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in;
  logic [NN-1:0][PW-1:0] phase_in;
  logic [NN-1:0]         gate_in;
  logic [NN-1:0][AW-1:0] addr_out;
  logic [NV-1:0][AW-1:0] voice_addr_out;
  logic [NV-1:0][IW-1:0] active_voices_idx;
  logic [NN-1:0]         active_voices;
  logic [CW-1:0]         num_voices;
  logic                  frame_valid;

  logic [SN-1:0][PW-1:0]  s_phase;
  logic [SN-1:0]          s_gate;
  logic [SN-1:0][AW-1:0]  s_addr;
  logic [SV-1:0][AW-1:0]  s_vaddr;
  logic [SV-1:0][SIW-1:0] s_idx;
  logic [SN-1:0]          s_active;
  logic [SCW-1:0]         s_num;
  logic                   s_fv;

`ifdef VOICE_ALLOC_DROP_COUNT_EN
  logic [7:0] dropped_count, s_dropped;
  logic [0:0] overflow, s_overflow;
`endif

  voice_allocator u_dut (
    .clk_in(clk), .rst_in(rst_in), .phase_in(phase_in), .gate_in(gate_in),
    .addr_out(addr_out), .voice_addr_out(voice_addr_out),
    .active_voices_idx(active_voices_idx), .active_voices(active_voices),
    .num_voices(num_voices),
`ifdef VOICE_ALLOC_DROP_COUNT_EN
    .dropped_count(dropped_count), .overflow(overflow),
`endif
    .frame_valid(frame_valid)
  );

  voice_allocator #(.NUM_NOTES(SN), .NUM_VOICES(SV), .NOTES_PER_GROUP(4)) u_small (
    .clk_in(clk), .rst_in(rst_in), .phase_in(s_phase), .gate_in(s_gate),
    .addr_out(s_addr), .voice_addr_out(s_vaddr),
    .active_voices_idx(s_idx), .active_voices(s_active),
    .num_voices(s_num),
`ifdef VOICE_ALLOC_DROP_COUNT_EN
    .dropped_count(s_dropped), .overflow(s_overflow),
`endif
    .frame_valid(s_fv)
  );

  int total = 0;
  int bad   = 0;

  // Reference expectations for one frame of the default instance.
  int              exp_num;
  int              exp_drop;
  logic [NN-1:0]   exp_active;
  int              exp_idx [NV];
  logic [AW-1:0]   exp_vaddr [NV];
  logic [AW-1:0]   exp_addr [NN];

  // Reference: list gated notes in index order, first NV get voices.
  task automatic model_frame(input logic [NN-1:0] g);
    int q[$];
    q = {};
    for (int n = 0; n < NN; n++) if (g[n]) q.push_back(n);
    exp_num    = (q.size() < NV) ? q.size() : NV;
    exp_drop   = q.size() - exp_num;
    exp_active = '0;
    for (int s = 0; s < NV; s++) begin
      if (s < exp_num) begin
        exp_idx[s]         = q[s];
        exp_vaddr[s]       = phase_in[q[s]][PW-1 -: AW];
        exp_active[q[s]]   = 1'b1;
      end else begin
        exp_idx[s]   = (1 << IW) - 1;
        exp_vaddr[s] = '0;
      end
    end
    for (int n = 0; n < NN; n++)
      exp_addr[n] = exp_active[n] ? phase_in[n][PW-1 -: AW] : '0;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic randomize_phases();
    for (int n = 0; n < NN; n++) phase_in[n] = $urandom;
  endtask

  task automatic test_reset();
    int lat;
    gate_in = '1;
    randomize_phases();
    rst_in = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (num_voices !== '0) begin bad++; $display("FAIL reset_num got=%0d want=0", num_voices); end
    total++; if (active_voices !== '0) begin bad++; $display("FAIL reset_active got=%h want=0", active_voices); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b want=0", frame_valid); end
    for (int s = 0; s < NV; s++) begin
      total++; if (active_voices_idx[s] !== 5'h1F) begin bad++; $display("FAIL reset_idx[%0d] got=%h want=1f", s, active_voices_idx[s]); end
      total++; if (voice_addr_out[s] !== '0) begin bad++; $display("FAIL reset_vaddr[%0d] got=%h want=0", s, voice_addr_out[s]); end
    end
    for (int n = 0; n < NN; n++) begin
      total++; if (addr_out[n] !== '0) begin bad++; $display("FAIL reset_addr[%0d] got=%h want=0", n, addr_out[n]); end
    end
`ifdef VOICE_ALLOC_DROP_COUNT_EN
    total++; if (dropped_count !== 8'd0 || overflow !== 1'b0) begin bad++; $display("FAIL reset_drop got=%0d/%b want=0/0", dropped_count, overflow); end
`endif
    rst_in = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin lat = k; break; end
    end
    total++; if (lat != 4) begin bad++; $display("FAIL first_frame_latency got=%0d want=4", lat); end
    @(negedge clk);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL fv_pulse got=%b want=0", frame_valid); end
  endtask

  task automatic test_saturation();
    bit ok;
    wait_frame(ok);
    gate_in = '1;
    randomize_phases();
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_timeout got=none want=frame_valid"); end
    total++; if (num_voices !== 4'd8) begin bad++; $display("FAIL sat_num got=%0d want=8", num_voices); end
    total++; if (active_voices !== 24'h0000FF) begin bad++; $display("FAIL sat_active got=%h want=0000ff", active_voices); end
    for (int s = 0; s < NV; s++) begin
      total++; if (active_voices_idx[s] !== IW'(s)) begin bad++; $display("FAIL sat_idx[%0d] got=%0d want=%0d", s, active_voices_idx[s], s); end
      total++; if (voice_addr_out[s] !== phase_in[s][PW-1 -: AW]) begin bad++; $display("FAIL sat_vaddr[%0d] got=%h want=%h", s, voice_addr_out[s], phase_in[s][PW-1 -: AW]); end
    end
    for (int n = 0; n < NN; n++) begin
      logic [AW-1:0] want;
      want = (n < NV) ? phase_in[n][PW-1 -: AW] : '0;
      total++; if (addr_out[n] !== want) begin bad++; $display("FAIL sat_addr[%0d] got=%h want=%h", n, addr_out[n], want); end
    end
`ifdef VOICE_ALLOC_DROP_COUNT_EN
    total++; if (dropped_count !== 8'd16 || overflow !== 1'b1) begin bad++; $display("FAIL sat_drop got=%0d/%b want=16/1", dropped_count, overflow); end
`endif
  endtask

  task automatic test_single_note();
    bit ok;
    wait_frame(ok);
    randomize_phases();
    gate_in = '0;
    gate_in[5] = 1'b1;
    phase_in[5] = 32'hAB12_3456;
    @(negedge clk);
    total++; if (addr_out[5] !== 8'hAB) begin bad++; $display("FAIL single_addr5 got=%h want=ab", addr_out[5]); end
    total++; if (addr_out[4] !== 8'h00) begin bad++; $display("FAIL single_addr4 got=%h want=00", addr_out[4]); end
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=none want=frame_valid"); end
    total++; if (num_voices !== 4'd1) begin bad++; $display("FAIL single_num got=%0d want=1", num_voices); end
    total++; if (active_voices_idx[0] !== 5'd5) begin bad++; $display("FAIL single_idx0 got=%0d want=5", active_voices_idx[0]); end
    total++; if (voice_addr_out[0] !== 8'hAB) begin bad++; $display("FAIL single_vaddr0 got=%h want=ab", voice_addr_out[0]); end
    total++; if (active_voices !== 24'h000020) begin bad++; $display("FAIL single_active got=%h want=000020", active_voices); end
    for (int s = 1; s < NV; s++) begin
      total++; if (active_voices_idx[s] !== 5'h1F || voice_addr_out[s] !== '0) begin bad++; $display("FAIL single_unused[%0d] got=%h/%h want=1f/00", s, active_voices_idx[s], voice_addr_out[s]); end
    end
`ifdef VOICE_ALLOC_DROP_COUNT_EN
    total++; if (dropped_count !== 8'd0 || overflow !== 1'b0) begin bad++; $display("FAIL single_drop got=%0d/%b want=0/0", dropped_count, overflow); end
`endif
  endtask

  task automatic test_cross_group();
    bit ok;
    int want [4] = '{3, 9, 17, 23};
    wait_frame(ok);
    randomize_phases();
    gate_in = '0;
    for (int i = 0; i < 4; i++) gate_in[want[i]] = 1'b1;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL cross_timeout got=none want=frame_valid"); end
    total++; if (num_voices !== 4'd4) begin bad++; $display("FAIL cross_num got=%0d want=4", num_voices); end
    for (int s = 0; s < NV; s++) begin
      logic [IW-1:0] w;
      w = (s < 4) ? IW'(want[s]) : 5'h1F;
      total++; if (active_voices_idx[s] !== w) begin bad++; $display("FAIL cross_idx[%0d] got=%0d want=%0d", s, active_voices_idx[s], w); end
    end
  endtask

  task automatic test_midframe_gate();
    bit ok;
    wait_frame(ok);
    gate_in = '0;
    @(negedge clk);
    gate_in[2] = 1'b1;
    wait_frame(ok);
    total++; if (num_voices !== 4'd0 || active_voices !== '0) begin bad++; $display("FAIL mid_current got=%0d/%h want=0/0", num_voices, active_voices); end
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout got=none want=frame_valid"); end
    total++; if (num_voices !== 4'd1 || active_voices_idx[0] !== 5'd2) begin bad++; $display("FAIL mid_next got=%0d/%0d want=1/2", num_voices, active_voices_idx[0]); end
  endtask

  task automatic test_random();
    bit ok;
    wait_frame(ok);
    for (int f = 0; f < 25; f++) begin
      randomize_phases();
      case ($urandom_range(0, 3))
        0: gate_in = NN'($urandom) & NN'($urandom) & NN'($urandom);
        1: gate_in = NN'($urandom) & NN'($urandom);
        2: gate_in = NN'($urandom);
        default: gate_in = NN'($urandom) | NN'($urandom);
      endcase
      wait_frame(ok);
      total++; if (!ok) begin bad++; $display("FAIL rand_timeout frame=%0d got=none want=frame_valid", f); end
      model_frame(gate_in);
      total++; if (num_voices !== CW'(exp_num)) begin bad++; $display("FAIL rand_num frame=%0d got=%0d want=%0d", f, num_voices, exp_num); end
      total++; if (active_voices !== exp_active) begin bad++; $display("FAIL rand_active frame=%0d got=%h want=%h", f, active_voices, exp_active); end
      for (int s = 0; s < NV; s++) begin
        total++; if (active_voices_idx[s] !== IW'(exp_idx[s]) || voice_addr_out[s] !== exp_vaddr[s]) begin
          bad++; $display("FAIL rand_slot[%0d] frame=%0d got=%0d/%h want=%0d/%h", s, f, active_voices_idx[s], voice_addr_out[s], exp_idx[s], exp_vaddr[s]);
        end
      end
      for (int n = 0; n < NN; n++) begin
        total++; if (addr_out[n] !== exp_addr[n]) begin bad++; $display("FAIL rand_addr[%0d] frame=%0d got=%h want=%h", n, f, addr_out[n], exp_addr[n]); end
      end
`ifdef VOICE_ALLOC_DROP_COUNT_EN
      total++; if (dropped_count !== 8'(exp_drop) || overflow !== (exp_drop > 0)) begin bad++; $display("FAIL rand_drop frame=%0d got=%0d/%b want=%0d", f, dropped_count, overflow, exp_drop); end
`endif
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int lat;
    bit seen_fv;
    wait_frame(ok);
    gate_in = '1;
    wait_frame(ok);
    total++; if (num_voices !== 4'd8) begin bad++; $display("FAIL rmid_pre got=%0d want=8", num_voices); end
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    seen_fv = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (frame_valid !== 1'b0) seen_fv = 1'b1;
    end
    total++; if (seen_fv) begin bad++; $display("FAIL rmid_fv got=1 want=0"); end
    total++; if (num_voices !== '0 || active_voices !== '0 || active_voices_idx[0] !== 5'h1F) begin
      bad++; $display("FAIL rmid_snapshot got=%0d/%h/%h want=0/0/1f", num_voices, active_voices, active_voices_idx[0]);
    end
    rst_in = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin lat = k; break; end
    end
    total++; if (lat != 4) begin bad++; $display("FAIL rmid_latency got=%0d want=4", lat); end
    total++; if (num_voices !== 4'd8) begin bad++; $display("FAIL rmid_after got=%0d want=8", num_voices); end
  endtask

  task automatic test_small_params();
    int lat;
    for (int n = 0; n < SN; n++) s_phase[n] = $urandom;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (s_fv === 1'b1) begin lat = k; break; end
    end
    total++; if (lat < 0) begin bad++; $display("FAIL small_timeout got=none want=frame_valid"); end
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (s_fv === 1'b1) begin lat = k; break; end
    end
    total++; if (lat != 4) begin bad++; $display("FAIL small_period got=%0d want=4", lat); end
    total++; if (s_num !== 2'd3) begin bad++; $display("FAIL small_num got=%0d want=3", s_num); end
    total++; if (s_active !== 10'h007) begin bad++; $display("FAIL small_active got=%h want=007", s_active); end
    for (int s = 0; s < SV; s++) begin
      total++; if (s_idx[s] !== SIW'(s) || s_vaddr[s] !== s_phase[s][PW-1 -: AW]) begin
        bad++; $display("FAIL small_slot[%0d] got=%0d/%h want=%0d/%h", s, s_idx[s], s_vaddr[s], s, s_phase[s][PW-1 -: AW]);
      end
    end
    for (int n = 0; n < SN; n++) begin
      logic [AW-1:0] want;
      want = (n < SV) ? s_phase[n][PW-1 -: AW] : '0;
      total++; if (s_addr[n] !== want) begin bad++; $display("FAIL small_addr[%0d] got=%h want=%h", n, s_addr[n], want); end
    end
`ifdef VOICE_ALLOC_DROP_COUNT_EN
    total++; if (s_dropped !== 8'd7 || s_overflow !== 1'b1) begin bad++; $display("FAIL small_drop got=%0d/%b want=7/1", s_dropped, s_overflow); end
`endif
  endtask

  initial begin
    rst_in   = 1'b0;
    gate_in  = '0;
    phase_in = '0;
    s_gate   = '1;
    for (int n = 0; n < SN; n++) s_phase[n] = $urandom;
    test_reset();
    test_saturation();
    test_single_note();
    test_cross_group();
    test_midframe_gate();
    test_random();
    test_reset_midframe();
    test_small_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
